// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op and FSM state encodings
// (also used by the control unit) and the iteration-counter width function.
// No logic of its own.
package mul_div_unit_pkg;

  // Operation select, as driven by the control unit.
  typedef enum logic [1:0] {
    OP_MULU  = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } md_op_e;

  // Iterative-unit state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  // The counter must hold values 0..N-1, with one spare bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide (MULU, MULHU, DIVU, REMU), one operand bit per cycle.
// Latency: done pulses N+1 cycles after the accepting edge; a zero divisor gives done after 1 cycle.
// Backpressure: start is ignored while busy; accepted in IDLE or in the done cycle (back-to-back).
//
// Ports: clk, rst_n (async, active low); start/op/operand_a/operand_b request inputs;
//        busy, done (1-cycle pulse), result (held until next accepted start),
//        div_by_zero (valid with result). All outputs come straight from flops.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         div_by_zero
);

  localparam int unsigned CW = cnt_width(N);

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d;
  logic [N-1:0]    b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  acc_q, acc_d;      // operand_a is latched into the low half
  logic [N-1:0]    result_q, result_d;
  logic            dbz_q, dbz_d;

  logic            start_ok;
  logic            dbz_start;
  logic            last_iter;
  logic [N:0]      mul_sum;
  logic [N:0]      div_rem;
  logic            div_ge;
  logic [N-1:0]    div_sub;
  logic [2*N-1:0]  acc_iter;
  logic [N-1:0]    iter_result;

  assign start_ok  = start && (state_q != ST_BUSY);
  // A zero divisor is resolved at acceptance, so the unit never enters BUSY for it.
  assign dbz_start = start_ok && op[1] && (operand_b == '0);
  assign last_iter = (cnt_q == CW'(N - 1));

  // One iteration step on the accumulator.
  always_comb begin
    // Multiply: add multiplier into the high half when the current LSB is set,
    // then shift the whole accumulator right (carry goes into the top bit).
    mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Restoring divide: shift left by one; the partial remainder needs N+1 bits
    // because it can reach up to 2*divisor-1 before the trial subtract.
    div_rem = acc_q[2*N-1:N-1];
    div_ge  = (div_rem >= {1'b0, b_q});
    div_sub = div_rem[N-1:0] - b_q;
    if (op_q[1]) begin
      acc_iter = {(div_ge ? div_sub : div_rem[N-1:0]), acc_q[N-2:0], div_ge};
    end else begin
      acc_iter = {mul_sum, acc_q[N-1:1]};
    end
    // Final select: the low half holds the product low word or the quotient,
    // the high half the product high word or the remainder.
    case (op_q)
      OP_MULU:  iter_result = acc_iter[N-1:0];
      OP_MULHU: iter_result = acc_iter[2*N-1:N];
      OP_DIVU:  iter_result = acc_iter[N-1:0];
      OP_REMU:  iter_result = acc_iter[2*N-1:N];
      default:  iter_result = '0;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    op_d     = op_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    if (start_ok) begin
      op_d  = md_op_e'(op);
      b_d   = operand_b;
      cnt_d = '0;
      acc_d = {{N{1'b0}}, operand_a};
      dbz_d = dbz_start;
      if (dbz_start) begin
        result_d = (md_op_e'(op) == OP_DIVU) ? '1 : operand_a;
      end
    end else if (state_q == ST_BUSY) begin
      acc_d = acc_iter;
      cnt_d = cnt_q + CW'(1);
      if (last_iter) begin
        result_d = iter_result;
      end
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = dbz_start ? ST_DONE : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: decoded from registered state only.
  always_comb begin
    busy        = (state_q == ST_BUSY);
    done        = (state_q == ST_DONE);
    result      = result_q;
    div_by_zero = dbz_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULU;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: a table of operations with hand-computed
// results and done cycles, run back-to-back, plus sequences for ignored start and
// reset in the middle of an operation.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int N     = 32;
  localparam int LIMIT = 60;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] operand_a;
  logic [N-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         div_by_zero;

  int           n_cmp;
  int           n_err;
  logic [N-1:0] prev_res;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  mul_div_unit #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the start is accepted at the following posedge (edge 0).
  task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r,
                         input logic exp_z, input int exp_c);
    int cyc;
    bit busy_bad;
    bit hold_bad;
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    busy_bad = 0;
    hold_bad = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (result !== prev_res) hold_bad = 1;
      @(negedge clk);
      cyc++;
    end
    chk({name, " done_cycle"}, 32'(cyc), 32'(exp_c));
    chk({name, " busy_window"}, {31'd0, busy_bad}, 32'd0);
    chk({name, " result_hold"}, {31'd0, hold_bad}, 32'd0);
    chk({name, " result"}, result, exp_r);
    chk({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_z});
    chk({name, " busy_in_done"}, {31'd0, busy}, 32'd0);
    prev_res = exp_r;
  endtask

  initial begin
    int cyc;
    bit saw_done;
    n_cmp     = 0;
    n_err     = 0;
    prev_res  = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = 2'b00;
    operand_a = '0;
    operand_b = '0;

    vecs[0]  = '{OP_MULU,  32'd7,          32'd6,          32'h0000002A, 1'b0, 33};
    vecs[1]  = '{OP_MULHU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 1'b0, 33};
    vecs[2]  = '{OP_MULU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0, 33};
    vecs[3]  = '{OP_DIVU,  32'd100,        32'd7,          32'h0000000E, 1'b0, 33};
    vecs[4]  = '{OP_REMU,  32'd100,        32'd7,          32'h00000002, 1'b0, 33};
    vecs[5]  = '{OP_DIVU,  32'd5,          32'd0,          32'hFFFFFFFF, 1'b1, 1};
    vecs[6]  = '{OP_REMU,  32'd5,          32'd0,          32'h00000005, 1'b1, 1};
    vecs[7]  = '{OP_DIVU,  32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 1'b0, 33};
    vecs[8]  = '{OP_REMU,  32'hFFFFFFFF,   32'h00000010,   32'h0000000F, 1'b0, 33};
    vecs[9]  = '{OP_MULHU, 32'h80000000,   32'd2,          32'h00000001, 1'b0, 33};
    vecs[10] = '{OP_DIVU,  32'd7,          32'd100,        32'h00000000, 1'b0, 33};
    vecs[11] = '{OP_REMU,  32'hDEADBEEF,   32'h00010000,   32'h0000BEEF, 1'b0, 33};
    vecs[12] = '{OP_MULU,  32'h12345678,   32'h00000010,   32'h23456780, 1'b0, 33};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst div_by_zero", {31'd0, div_by_zero}, 32'd0);

    // Release and start on the very first edge afterwards; table runs back-to-back,
    // each new start issued in the previous done cycle.
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].res, vecs[i].dbz, vecs[i].cyc);
    end

    // Start pulsed mid-operation must be ignored.
    @(negedge clk);
    @(negedge clk);
    op        = OP_MULU;
    operand_a = 32'd3;
    operand_b = 32'd4;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (cyc == 10) begin
        op        = OP_MULHU;
        operand_a = 32'hFFFFFFFF;
        operand_b = 32'd5;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("ignore done_cycle", 32'(cyc), 32'd33);
    chk("ignore result", result, 32'h0000000C);
    chk("ignore div_by_zero", {31'd0, div_by_zero}, 32'd0);
    prev_res = 32'h0000000C;

    // Reset in the middle of a divide.
    @(negedge clk);
    op        = OP_DIVU;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst div_by_zero", {31'd0, div_by_zero}, 32'd0);
    prev_res = '0;
    saw_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    chk("midrst quiet", {31'd0, saw_done}, 32'd0);
    rst_n = 1'b1;
    run_vec("post_rst", OP_MULU, 32'd2, 32'd2, 32'h00000004, 1'b0, 33);

    // After done, with no new start, the unit goes idle and holds the result.
    @(negedge clk);
    chk("idle done", {31'd0, done}, 32'd0);
    chk("idle result", result, 32'h00000004);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
